// File: rtl/jpeg_quant_zigzag_if.sv
// Stream/bus bundle for jpeg_quant_zigzag: block input, reciprocal table port,
// DC predictor clear and the zigzag output stream.
interface jpeg_quant_zigzag_if #(
    parameter int OUT_W = 11
);
    logic                    blk_valid;
    logic                    blk_ready;
    logic signed [7:0]       coef [0:63];
    logic                    q_we;
    logic [5:0]              q_addr;
    logic [15:0]             q_data;
    logic                    dc_clear;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [5:0]              out_idx;
    logic                    out_last;
    logic                    overflow;

    modport master (
        output blk_valid, coef, q_we, q_addr, q_data, dc_clear, out_ready,
        input  blk_ready, out_valid, out_data, out_idx, out_last, overflow
    );

    modport slave (
        input  blk_valid, coef, q_we, q_addr, q_data, dc_clear, out_ready,
        output blk_ready, out_valid, out_data, out_idx, out_last, overflow
    );
endinterface

// File: rtl/jpeg_quant_zigzag.sv
// 8x8 block quantizer (reciprocal multiply, round half up) with zigzag serial output.
// Optional DC differencing is enabled by defining JPEG_QZ_DC_DIFF_EN.
module jpeg_quant_zigzag #(
    parameter int          OUT_W     = 11,
    parameter logic [15:0] RECIP_RST = 16'hFFFF
) (
    input logic               clock,
    input logic               reset,
    jpeg_quant_zigzag_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [5:0] ZZ [0:63] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    state_t                  state_reg, state_next;
    logic signed [7:0]       coef_buf_reg [0:63];
    logic [15:0]             recip_reg [0:63];
    logic [5:0]              k_reg;
    logic                    out_valid_reg;
    logic signed [OUT_W-1:0] out_data_reg;
    logic [5:0]              out_idx_reg;
    logic                    out_last_reg;
    logic                    overflow_reg;

    logic                    accept_blk;
    logic                    load;
    logic                    tab_we;
    logic [5:0]              zz;
    logic signed [7:0]       coef_sel;
    logic signed [16:0]      recip_sel;
    logic signed [24:0]      prod;
    logic signed [24:0]      rounded;
    logic signed [OUT_W-1:0] q_ext;
    logic signed [OUT_W-1:0] word;

    assign accept_blk = (state_reg == IDLE) && bus.blk_valid;
    assign load       = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);
    assign tab_we     = (state_reg == IDLE) && bus.q_we;

    // Reciprocal is unsigned; a zero MSB keeps the signed multiply exact.
    assign zz        = ZZ[k_reg];
    assign coef_sel  = coef_buf_reg[zz];
    assign recip_sel = $signed({1'b0, recip_reg[zz]});
    assign prod      = 25'(coef_sel) * 25'(recip_sel);
    assign rounded   = prod + 25'sd32768;
    assign q_ext     = OUT_W'(rounded >>> 16);

`ifdef JPEG_QZ_DC_DIFF_EN
    logic signed [OUT_W-1:0] dc_pred_reg;
    logic signed [OUT_W-1:0] dc_pred_eff;

    // A clear coinciding with the DC load must already see a zero predictor.
    assign dc_pred_eff = bus.dc_clear ? '0 : dc_pred_reg;
    assign word        = (k_reg == 6'd0) ? (q_ext - dc_pred_eff) : q_ext;

    always_ff @(posedge clock) begin
        if (reset) begin
            dc_pred_reg <= '0;
        end else if (load && (k_reg == 6'd0)) begin
            dc_pred_reg <= q_ext;
        end else if (bus.dc_clear) begin
            dc_pred_reg <= '0;
        end
    end
`else
    logic unused_dc_clear;
    assign unused_dc_clear = bus.dc_clear;
    assign word            = q_ext;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.blk_valid) state_next = RUN;
            RUN:     if (load && (k_reg == 6'd63)) state_next = DRAIN;
            DRAIN:   if (out_valid_reg && bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_blk) begin
                k_reg <= '0;
            end else if (load) begin
                k_reg <= k_reg + 6'd1;
            end
            if (load) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= word;
                out_idx_reg   <= k_reg;
                out_last_reg  <= (k_reg == 6'd63);
            end else if ((state_reg == DRAIN) && out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (bus.blk_valid && (state_reg != IDLE)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Table is frozen outside IDLE so every block sees one consistent table.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                recip_reg[i] <= RECIP_RST;
            end
        end else if (tab_we) begin
            recip_reg[bus.q_addr] <= bus.q_data;
        end
    end

    always_ff @(posedge clock) begin
        if (accept_blk) begin
            for (int i = 0; i < 64; i++) begin
                coef_buf_reg[i] <= bus.coef[i];
            end
        end
    end

    assign bus.blk_ready = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.overflow  = overflow_reg;
endmodule
